// File: rtl/mem_responder_if.sv
// Arbiter <-> main memory request/response bundle.
// master = arbiter side (drives requests, sinks responses); slave = memory side.
// Widths come from MEM_ADDR_BITS / MEM_DATA_BITS / MEM_TAG_BITS, defaulted here when not set by the build.

`ifndef MEM_ADDR_BITS
`define MEM_ADDR_BITS 26
`endif
`ifndef MEM_DATA_BITS
`define MEM_DATA_BITS 128
`endif
`ifndef MEM_TAG_BITS
`define MEM_TAG_BITS 5
`endif

interface mem_responder_if;
    logic                           mem_req_valid;
    logic                           mem_req_ready;
    logic                           mem_req_rw;
    logic [`MEM_ADDR_BITS-1:0]      mem_req_addr;
    logic [`MEM_TAG_BITS-1:0]       mem_req_tag;
    logic                           mem_req_data_valid;
    logic                           mem_req_data_ready;
    logic [`MEM_DATA_BITS-1:0]      mem_req_data_bits;
    logic [`MEM_DATA_BITS/8-1:0]    mem_req_data_mask;
    logic                           mem_resp_valid;
    logic [`MEM_DATA_BITS-1:0]      mem_resp_data;
    logic [`MEM_TAG_BITS-1:0]       mem_resp_tag;

    modport master (
        output mem_req_valid, mem_req_rw, mem_req_addr, mem_req_tag,
               mem_req_data_valid, mem_req_data_bits, mem_req_data_mask,
        input  mem_req_ready, mem_req_data_ready,
               mem_resp_valid, mem_resp_data, mem_resp_tag
    );

    modport slave (
        input  mem_req_valid, mem_req_rw, mem_req_addr, mem_req_tag,
               mem_req_data_valid, mem_req_data_bits, mem_req_data_mask,
        output mem_req_ready, mem_req_data_ready,
               mem_resp_valid, mem_resp_data, mem_resp_tag
    );
endinterface

// File: rtl/mem_responder.sv
// mem_responder: far end of the arbiter <-> main memory link.
// Stores MEM_DATA_BITS-wide beats in an internal array, accepts one transaction at a time,
// and returns reads as gap-free bursts of BEATS beats echoing the request tag.
// Optional feature: define MEMRESP_RANDOM_STALL_EN to add an LFSR that randomly withholds
// req_ready / data_ready (response bursts are never stalled).
//
// state       | meaning
// ------------+----------------------------------------------------------
// ST_IDLE     | ready for a new request
// ST_WR_DATA  | collecting BEATS write data beats, byte-masked into array
// ST_RD_WAIT  | counting down the read latency
// ST_RD_BURST | presenting one read beat per cycle, BEATS in total

`ifndef MEM_ADDR_BITS
`define MEM_ADDR_BITS 26
`endif
`ifndef MEM_DATA_BITS
`define MEM_DATA_BITS 128
`endif
`ifndef MEM_TAG_BITS
`define MEM_TAG_BITS 5
`endif

module mem_responder #(
    parameter int DEPTH_LOG2   = 14,
    parameter int BEATS        = 4,
    parameter int READ_LATENCY = 8
) (
    input  logic           clk,
    input  logic           reset_n,
    mem_responder_if.slave bus
);

    localparam int ADDR_W    = `MEM_ADDR_BITS;
    localparam int DATA_W    = `MEM_DATA_BITS;
    localparam int TAG_W     = `MEM_TAG_BITS;
    localparam int MASK_W    = DATA_W / 8;
    localparam int BEAT_BITS = (BEATS > 1) ? $clog2(BEATS) : 0;
    localparam int CNT_W     = (BEATS > 1) ? BEAT_BITS : 1;
    localparam int LAT_W     = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
    localparam int FULL_W    = ADDR_W + BEAT_BITS;
    localparam int DEPTH     = 1 << DEPTH_LOG2;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WR_DATA  = 2'd1,
        ST_RD_WAIT  = 2'd2,
        ST_RD_BURST = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [TAG_W-1:0]    tag_q, tag_d;
    logic [CNT_W-1:0]    beat_cnt_q, beat_cnt_d;
    logic [LAT_W-1:0]    lat_cnt_q, lat_cnt_d;
    logic [DATA_W-1:0]   resp_data_q;
    logic [TAG_W-1:0]    resp_tag_q, resp_tag_d;

    logic                   req_ready;
    logic                   data_ready;
    logic                   wr_en;
    logic                   rd_en;
    logic [DEPTH_LOG2-1:0]  wr_idx;
    logic [DEPTH_LOG2-1:0]  rd_idx;
    logic                   stall;
    logic                   last_beat;

    logic [DATA_W-1:0] mem_array [DEPTH];

    // Array index is {addr, beat}; upper bits beyond the array depth are dropped, so addresses alias.
    function automatic logic [DEPTH_LOG2-1:0] beat_index(input logic [ADDR_W-1:0] a,
                                                         input logic [CNT_W-1:0]  b);
        return DEPTH_LOG2'((FULL_W'(a) << BEAT_BITS) | FULL_W'(b));
    endfunction

`ifdef MEMRESP_RANDOM_STALL_EN
    logic [15:0] lfsr_q, lfsr_d;

    // Fibonacci LFSR, taps 16,14,13,11, shifting right.
    always_comb begin
        lfsr_d = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
    end

    // LFSR free-runs every cycle from a fixed seed.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) lfsr_q <= 16'hACE1;
        else          lfsr_q <= lfsr_d;
    end

    assign stall = (lfsr_q[1:0] == 2'b00);
`else
    assign stall = 1'b0;
`endif

    assign last_beat = (beat_cnt_q == CNT_W'(BEATS - 1));
    assign wr_idx    = beat_index(addr_q, beat_cnt_q);

    // Next-state, handshake and array-access decode.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        tag_d      = tag_q;
        beat_cnt_d = beat_cnt_q;
        lat_cnt_d  = lat_cnt_q;
        resp_tag_d = resp_tag_q;
        req_ready  = 1'b0;
        data_ready = 1'b0;
        wr_en      = 1'b0;
        rd_en      = 1'b0;
        rd_idx     = beat_index(addr_q, beat_cnt_q);

        case (state_q)
            ST_IDLE: begin
                req_ready = ~stall;
                if (bus.mem_req_valid && req_ready) begin
                    addr_d     = bus.mem_req_addr;
                    tag_d      = bus.mem_req_tag;
                    beat_cnt_d = '0;
                    if (bus.mem_req_rw) begin
                        state_d = ST_WR_DATA;
                    end else if (READ_LATENCY == 1) begin
                        // Zero wait: fetch beat 0 now so it is presented the next cycle.
                        state_d    = ST_RD_BURST;
                        rd_en      = 1'b1;
                        rd_idx     = beat_index(bus.mem_req_addr, '0);
                        resp_tag_d = bus.mem_req_tag;
                    end else begin
                        state_d   = ST_RD_WAIT;
                        lat_cnt_d = LAT_W'(READ_LATENCY - 1);
                    end
                end
            end

            ST_WR_DATA: begin
                data_ready = ~stall;
                if (bus.mem_req_data_valid && data_ready) begin
                    wr_en = 1'b1;
                    if (last_beat) begin
                        state_d    = ST_IDLE;
                        beat_cnt_d = '0;
                    end else begin
                        beat_cnt_d = beat_cnt_q + CNT_W'(1);
                    end
                end
            end

            ST_RD_WAIT: begin
                lat_cnt_d = lat_cnt_q - LAT_W'(1);
                // Counter reaches zero on this edge: beat 0 is fetched into the output register now.
                if (lat_cnt_q == LAT_W'(1)) begin
                    state_d    = ST_RD_BURST;
                    rd_en      = 1'b1;
                    rd_idx     = beat_index(addr_q, '0);
                    resp_tag_d = tag_q;
                end
            end

            ST_RD_BURST: begin
                if (last_beat) begin
                    state_d    = ST_IDLE;
                    beat_cnt_d = '0;
                end else begin
                    beat_cnt_d = beat_cnt_q + CNT_W'(1);
                    rd_en      = 1'b1;
                    rd_idx     = beat_index(addr_q, beat_cnt_q + CNT_W'(1));
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Control state registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            tag_q      <= '0;
            beat_cnt_q <= '0;
            lat_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            tag_q      <= tag_d;
            beat_cnt_q <= beat_cnt_d;
            lat_cnt_q  <= lat_cnt_d;
        end
    end

    // Response register: loads one beat ahead of presentation and otherwise holds its last value.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            resp_data_q <= '0;
            resp_tag_q  <= '0;
        end else begin
            resp_tag_q <= resp_tag_d;
            if (rd_en) begin
                resp_data_q <= mem_array[rd_idx];
            end
        end
    end

    // Byte-masked array write; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < MASK_W; b++) begin
                if (bus.mem_req_data_mask[b]) begin
                    mem_array[wr_idx][b*8 +: 8] <= bus.mem_req_data_bits[b*8 +: 8];
                end
            end
        end
    end

    // req_ready is held low for the whole time reset is asserted, not just after the first edge.
    assign bus.mem_req_ready      = req_ready & reset_n;
    assign bus.mem_req_data_ready = data_ready;
    assign bus.mem_resp_valid     = (state_q == ST_RD_BURST);
    assign bus.mem_resp_data      = resp_data_q;
    assign bus.mem_resp_tag       = resp_tag_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder (DATA=128, BEATS=4, READ_LATENCY=8, DEPTH_LOG2=14).
// With MEMRESP_RANDOM_STALL_EN defined, a random read/write run against a line scoreboard is added.

`ifndef MEM_ADDR_BITS
`define MEM_ADDR_BITS 26
`endif
`ifndef MEM_DATA_BITS
`define MEM_DATA_BITS 128
`endif
`ifndef MEM_TAG_BITS
`define MEM_TAG_BITS 5
`endif

module tb_mem_responder;

    localparam int AW = `MEM_ADDR_BITS;
    localparam int TW = `MEM_TAG_BITS;

    typedef logic [127:0] line_t [4];
    typedef logic [15:0]  mask_t [4];

    logic clk = 1'b0;
    logic reset_n;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   stalls = 0;

    mem_responder_if bus ();

    mem_responder #(
        .DEPTH_LOG2  (14),
        .BEATS       (4),
        .READ_LATENCY(8)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", name, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge with valid dropped.
    task automatic send_req(input logic rw, input logic [AW-1:0] a, input logic [TW-1:0] t,
                            output int acc);
        int n = 0;
        bus.mem_req_valid = 1'b1;
        bus.mem_req_rw    = rw;
        bus.mem_req_addr  = a;
        bus.mem_req_tag   = t;
        while (!bus.mem_req_ready && n < 50) begin
            stalls++;
            @(negedge clk);
            n++;
        end
        chk("req_accept_in_time", 128'(n < 50), 128'(1));
        @(posedge clk);
        #1 acc = cyc;
        @(negedge clk);
        bus.mem_req_valid = 1'b0;
    endtask

    task automatic send_data(input logic [127:0] d, input logic [15:0] m);
        int n = 0;
        bus.mem_req_data_valid = 1'b1;
        bus.mem_req_data_bits  = d;
        bus.mem_req_data_mask  = m;
        while (!bus.mem_req_data_ready && n < 50) begin
            stalls++;
            @(negedge clk);
            n++;
        end
        chk("data_accept_in_time", 128'(n < 50), 128'(1));
        @(posedge clk);
        @(negedge clk);
        bus.mem_req_data_valid = 1'b0;
    endtask

    task automatic wr_line(input logic [AW-1:0] a, input logic [TW-1:0] t,
                           input line_t d, input mask_t m);
        int acc;
        send_req(1'b1, a, t, acc);
        for (int k = 0; k < 4; k++) send_data(d[k], m[k]);
    endtask

    // Read a line; lat is cycles from accept edge to the edge launching beat 0.
    task automatic rd_line(input logic [AW-1:0] a, input logic [TW-1:0] t,
                           output line_t d, output logic [TW-1:0] tg [4], output int lat,
                           output logic [3:0] vld, output logic post_valid, output logic post_ready);
        int acc;
        int n = 0;
        send_req(1'b0, a, t, acc);
        while (!bus.mem_resp_valid && n < 64) begin
            @(negedge clk);
            n++;
        end
        lat = cyc - acc;
        for (int k = 0; k < 4; k++) begin
            d[k]   = bus.mem_resp_data;
            tg[k]  = bus.mem_resp_tag;
            vld[k] = bus.mem_resp_valid;
            @(negedge clk);
        end
        post_valid = bus.mem_resp_valid;
        post_ready = bus.mem_req_ready;
    endtask

    line_t            wd, rdd, ld;
    mask_t            full_m, part_m;
    logic [TW-1:0]    rtg [4];
    int               lat, acc, acc2, a1, nb, cnt;
    logic [3:0]       vld;
    logic             pv, pr;
    int               bcyc [8];
    logic [TW-1:0]    btag [8];
    logic [127:0]     bdat [8];

    initial begin
        reset_n                = 1'b0;
        bus.mem_req_valid      = 1'b0;
        bus.mem_req_rw         = 1'b0;
        bus.mem_req_addr       = '0;
        bus.mem_req_tag        = '0;
        bus.mem_req_data_valid = 1'b0;
        bus.mem_req_data_bits  = '0;
        bus.mem_req_data_mask  = '0;
        for (int k = 0; k < 4; k++) full_m[k] = 16'hFFFF;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_req_ready",  128'(bus.mem_req_ready), 128'(0));
        chk("rst_data_ready", 128'(bus.mem_req_data_ready), 128'(0));
        chk("rst_resp_valid", 128'(bus.mem_resp_valid), 128'(0));
        chk("rst_resp_data",  bus.mem_resp_data, 128'(0));
        chk("rst_resp_tag",   128'(bus.mem_resp_tag), 128'(0));
        reset_n = 1'b1;
        @(negedge clk);
        chk("rel_req_ready", 128'(bus.mem_req_ready), 128'(1));
        cnt = 0;
        repeat (10) begin
            @(negedge clk);
            if (bus.mem_resp_valid) cnt++;
        end
        chk("idle_no_resp", 128'(cnt), 128'(0));

        // Write data offered outside WR_DATA is not taken
        bus.mem_req_data_valid = 1'b1;
        #1 chk("idle_data_ready", 128'(bus.mem_req_data_ready), 128'(0));
        bus.mem_req_data_valid = 1'b0;
        @(negedge clk);

        // Full write then read, latency and data
        for (int k = 0; k < 4; k++) wd[k] = 128'h0011_2233_4455_6677_8899_AABB_CCDD_EEA0 + 128'(k);
        wr_line(26'h10, 5'd3, wd, full_m);
        rd_line(26'h10, 5'd7, rdd, rtg, lat, vld, pv, pr);
        chk("rd_latency", 128'(lat), 128'(7));
        chk("rd_valid_run", 128'(vld), 128'hF);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("rd_data%0d", k), rdd[k], wd[k]);
            chk($sformatf("rd_tag%0d", k), 128'(rtg[k]), 128'(7));
        end
        chk("rd_post_valid", 128'(pv), 128'(0));
        chk("rd_post_ready", 128'(pr), 128'(1));

        // Partial write over a line of zeros
        for (int k = 0; k < 4; k++) begin
            ld[k] = '0;
            part_m[k] = 16'h0000;
        end
        part_m[0] = 16'h000F;
        wr_line(26'h20, 5'd1, ld, full_m);
        for (int k = 0; k < 4; k++) ld[k] = {128{1'b1}};
        wr_line(26'h20, 5'd1, ld, part_m);
        rd_line(26'h20, 5'd2, rdd, rtg, lat, vld, pv, pr);
        chk("part_beat0", rdd[0], 128'hFFFF_FFFF);
        for (int k = 1; k < 4; k++) chk($sformatf("part_beat%0d", k), rdd[k], 128'(0));

        // Address wrap: 0x1000 aliases 0x0 with 2^14 beats of 4-beat lines
        for (int k = 0; k < 4; k++) ld[k] = 128'h5A5A_0000_0000_0000_0000_0000_1234_0000 + 128'(k * 17);
        wr_line(26'h1000, 5'd4, ld, full_m);
        rd_line(26'h0, 5'd4, rdd, rtg, lat, vld, pv, pr);
        for (int k = 0; k < 4; k++) chk($sformatf("wrap_beat%0d", k), rdd[k], ld[k]);

        // Back-to-back reads with valid held
        bus.mem_req_valid = 1'b1;
        bus.mem_req_rw    = 1'b0;
        bus.mem_req_addr  = 26'h10;
        bus.mem_req_tag   = 5'd1;
        @(posedge clk);
        #1 a1 = cyc;
        bus.mem_req_tag = 5'd2;
        acc2 = -1;
        nb = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.mem_req_valid && acc2 >= 0 && cyc >= acc2) bus.mem_req_valid = 1'b0;
            if (bus.mem_resp_valid) begin
                if (nb < 8) begin
                    bcyc[nb] = cyc - a1;
                    btag[nb] = bus.mem_resp_tag;
                    bdat[nb] = bus.mem_resp_data;
                end
                nb++;
            end
            if (bus.mem_req_valid && bus.mem_req_ready && acc2 < 0) acc2 = cyc + 1;
        end
        bus.mem_req_valid = 1'b0;
        chk("b2b_accept2", 128'(acc2 - a1), 128'(12));
        chk("b2b_beats", 128'(nb), 128'(8));
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("b2b_cyc%0d", k), 128'(bcyc[k]), 128'((k < 4) ? 7 + k : 15 + k));
            chk($sformatf("b2b_tag%0d", k), 128'(btag[k]), 128'((k < 4) ? 1 : 2));
            chk($sformatf("b2b_data%0d", k), bdat[k], wd[k % 4]);
        end

        // Reset during beat 2 of a read
        send_req(1'b0, 26'h10, 5'd5, acc);
        cnt = 0;
        while (!bus.mem_resp_valid && cnt < 64) begin
            @(negedge clk);
            cnt++;
        end
        repeat (2) @(negedge clk);
        chk("mid_beat2_data", bus.mem_resp_data, wd[2]);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_valid", 128'(bus.mem_resp_valid), 128'(0));
        chk("mid_rst_ready", 128'(bus.mem_req_ready), 128'(0));
        chk("mid_rst_data", bus.mem_resp_data, 128'(0));
        cnt = 0;
        repeat (2) begin
            @(negedge clk);
            if (bus.mem_resp_valid) cnt++;
        end
        reset_n = 1'b1;
        @(negedge clk);
        chk("mid_rel_ready", 128'(bus.mem_req_ready), 128'(1));
        repeat (12) begin
            @(negedge clk);
            if (bus.mem_resp_valid) cnt++;
        end
        chk("mid_no_more_beats", 128'(cnt), 128'(0));

        // Reset during a write keeps the beats already stored
        for (int k = 0; k < 4; k++) wd[k] = 128'hB0 + 128'(k);
        wr_line(26'h30, 5'd6, wd, full_m);
        send_req(1'b1, 26'h30, 5'd6, acc);
        send_data(128'hC0, 16'hFFFF);
        send_data(128'hC1, 16'hFFFF);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        rd_line(26'h30, 5'd8, rdd, rtg, lat, vld, pv, pr);
        chk("pw_beat0", rdd[0], 128'hC0);
        chk("pw_beat1", rdd[1], 128'hC1);
        chk("pw_beat2", rdd[2], 128'hB2);
        chk("pw_beat3", rdd[3], 128'hB3);

`ifdef MEMRESP_RANDOM_STALL_EN
        begin
            line_t         sb [8];
            logic [127:0]  dv;
            logic [15:0]   mv;
            int            a;
            stalls = 0;
            for (int i = 0; i < 8; i++) begin
                for (int k = 0; k < 4; k++) sb[i][k] = {$urandom, $urandom, $urandom, $urandom};
                wr_line(AW'(26'h200 + i), 5'd9, sb[i], full_m);
            end
            for (int i = 0; i < 1000; i++) begin
                a = $urandom_range(0, 7);
                if ($urandom_range(0, 1) == 1) begin
                    send_req(1'b1, AW'(26'h200 + a), 5'd10, acc);
                    for (int k = 0; k < 4; k++) begin
                        dv = {$urandom, $urandom, $urandom, $urandom};
                        mv = 16'($urandom);
                        for (int b = 0; b < 16; b++) if (mv[b]) sb[a][k][b*8 +: 8] = dv[b*8 +: 8];
                        send_data(dv, mv);
                    end
                end else begin
                    rd_line(AW'(26'h200 + a), 5'd11, rdd, rtg, lat, vld, pv, pr);
                    chk("rnd_lat", 128'(lat), 128'(7));
                    for (int k = 0; k < 4; k++) chk("rnd_data", rdd[k], sb[a][k]);
                end
            end
            chk("rnd_stall_seen", 128'(stalls > 0), 128'(1));
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
